tone_synth: RTL



---
 rtl/tone_pkg.sv | 47 ++++
 rtl/tone_lut.sv | 48 ++++
 rtl/tone_synth.sv | 83 ++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared constants and helpers for the tone synthesizer: note frequencies,
// octave encodings, code validity and the half-period formula.
`timescale 1ns/1ps
package tone_pkg;

    localparam logic [7:0] MUTE_CODE = 8'hFF;

    localparam logic [3:0] OCT_LOW  = 4'd0;
    localparam logic [3:0] OCT_MID  = 4'd1;
    localparam logic [3:0] OCT_HIGH = 4'd2;

    localparam longint unsigned F_C_MHZ = 64'd261630;
    localparam longint unsigned F_D_MHZ = 64'd293665;
    localparam longint unsigned F_E_MHZ = 64'd329628;
    localparam longint unsigned F_F_MHZ = 64'd349228;
    localparam longint unsigned F_G_MHZ = 64'd391995;
    localparam longint unsigned F_A_MHZ = 64'd440000;
    localparam longint unsigned F_B_MHZ = 64'd493883;

    localparam int HALF_W = 32;

    function automatic logic code_valid(input logic [7:0] code);
        return (code[7:4] <= OCT_HIGH) && (code[3:0] >= 4'd1) && (code[3:0] <= 4'd7);
    endfunction

    // Half-period in clk cycles for a code; 0 marks an invalid (silent) code.
    function automatic logic [HALF_W-1:0] half_period(input logic [7:0] code,
                                                      input longint unsigned clk_hz);
        longint unsigned f_mhz;
        longint unsigned base;
        if (!code_valid(code)) return '0;
        case (code[3:0])
            4'd1:    f_mhz = F_C_MHZ;
            4'd2:    f_mhz = F_D_MHZ;
            4'd3:    f_mhz = F_E_MHZ;
            4'd4:    f_mhz = F_F_MHZ;
            4'd5:    f_mhz = F_G_MHZ;
            4'd6:    f_mhz = F_A_MHZ;
            default: f_mhz = F_B_MHZ;
        endcase
        base = (clk_hz * 64'd1000) / (64'd2 * f_mhz);
        if (code[7:4] == OCT_LOW)  base = base << 1;
        if (code[7:4] == OCT_HIGH) base = base >> 1;
        return base[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/tone_lut.sv
// Combinational code-to-half-period lookup; the table is built at elaboration.
`timescale 1ns/1ps
module tone_lut
    import tone_pkg::*;
#(
    parameter longint unsigned CLK_HZ = 50_000_000,
    parameter int DIV_W = 18
) (
    input  logic [7:0]       code,
    output logic [DIV_W-1:0] half,
    output logic             valid
);

    if (half_period({OCT_LOW, 4'd1}, CLK_HZ) >= (64'd1 << DIV_W)) begin : g_width_check
        $error("DIV_W too narrow for the low-octave C half-period");
    end

    localparam logic [DIV_W-1:0] H_C = DIV_W'(half_period({OCT_MID, 4'd1}, CLK_HZ));
    localparam logic [DIV_W-1:0] H_D = DIV_W'(half_period({OCT_MID, 4'd2}, CLK_HZ));
    localparam logic [DIV_W-1:0] H_E = DIV_W'(half_period({OCT_MID, 4'd3}, CLK_HZ));
    localparam logic [DIV_W-1:0] H_F = DIV_W'(half_period({OCT_MID, 4'd4}, CLK_HZ));
    localparam logic [DIV_W-1:0] H_G = DIV_W'(half_period({OCT_MID, 4'd5}, CLK_HZ));
    localparam logic [DIV_W-1:0] H_A = DIV_W'(half_period({OCT_MID, 4'd6}, CLK_HZ));
    localparam logic [DIV_W-1:0] H_B = DIV_W'(half_period({OCT_MID, 4'd7}, CLK_HZ));

    logic [DIV_W-1:0] mid;

    always_comb begin
        valid = code_valid(code);
        case (code[3:0])
            4'd1:    mid = H_C;
            4'd2:    mid = H_D;
            4'd3:    mid = H_E;
            4'd4:    mid = H_F;
            4'd5:    mid = H_G;
            4'd6:    mid = H_A;
            4'd7:    mid = H_B;
            default: mid = '0;
        endcase
        case (code[7:4])
            OCT_LOW:  half = mid << 1;
            OCT_HIGH: half = mid >> 1;
            default:  half = mid;
        endcase
        if (!valid) half = '0;
    end

endmodule

// File: rtl/tone_synth.sv
// Square-wave buzzer driver: latches a note code and toggles tone_out every
// half-period, re-evaluating the requested code only at half-period boundaries.
`timescale 1ns/1ps
module tone_synth
    import tone_pkg::*;
#(
    parameter longint unsigned CLK_HZ = 50_000_000,
    parameter int DIV_W = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] note_code,
    output logic       tone_out,
    output logic       active,
    output logic       note_strobe,
    output logic [7:0] cur_code
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [DIV_W-1:0] counter;
    logic [DIV_W-1:0] half_cur;
    logic             cur_valid;
    logic             boundary;

    tone_lut #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) u_lut (
        .code  (cur_code),
        .half  (half_cur),
        .valid (cur_valid)
    );

    // An invalid cur_code cannot occur in RUN; treating it as a boundary
    // guarantees the machine falls back to IDLE rather than counting forever.
    assign boundary = !cur_valid || (counter == half_cur - {{(DIV_W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            tone_out    <= 1'b0;
            active      <= 1'b0;
            note_strobe <= 1'b0;
            cur_code    <= MUTE_CODE;
        end else begin
            note_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    tone_out <= 1'b0;
                    counter  <= '0;
                    if (code_valid(note_code)) begin
                        state       <= RUN;
                        cur_code    <= note_code;
                        active      <= 1'b1;
                        note_strobe <= 1'b1;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        counter <= '0;
                        if (note_code == cur_code) begin
                            tone_out <= ~tone_out;
                        end else if (code_valid(note_code)) begin
                            tone_out    <= ~tone_out;
                            cur_code    <= note_code;
                            note_strobe <= 1'b1;
                        end else begin
                            tone_out <= 1'b0;
                            state    <= IDLE;
                            active   <= 1'b0;
                            cur_code <= MUTE_CODE;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
